// File: rtl/mlcd_bus_sched.sv
// Arbiter and strobe sequencer for the shared MCU-LCD 8080 bus: single command accesses
// from the CPU side and full-frame GRAM pixel streams, with parameterised WR/RD timing.
module mlcd_bus_sched #(
    parameter int          WR_LOW    = 1,
    parameter int          WR_HIGH   = 1,
    parameter int          RD_LOW    = 4,
    parameter int          RD_HIGH   = 4,
    parameter logic [15:0] GRAM_CMD  = 16'h2C00,
    parameter int          FRAME_PIX = 384000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    output logic        frame_busy,
    output logic        frame_done,
    output logic        pixel_en,
    input  logic [15:0] pixel_data,
    input  logic        cmd_req,
    input  logic        cmd_rd,
    input  logic        cmd_rs,
    input  logic [15:0] cmd_wdata,
    output logic        cmd_ack,
    output logic [15:0] cmd_rdata,
    output logic        mlcd_cs,
    output logic        mlcd_wr,
    output logic        mlcd_rd,
    output logic        mlcd_rs,
    output logic [15:0] mlcd_data,
    output logic        mlcd_data_dir,
    input  logic [15:0] mlcd_data_in
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int PH_MAX = max2(max2(WR_LOW, WR_HIGH), max2(RD_LOW, RD_HIGH));
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam int CNT_W  = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;

    localparam logic [PH_W-1:0]  WR_L_LD  = PH_W'(WR_LOW - 1);
    localparam logic [PH_W-1:0]  WR_H_LD  = PH_W'(WR_HIGH - 1);
    localparam logic [PH_W-1:0]  RD_L_LD  = PH_W'(RD_LOW - 1);
    localparam logic [PH_W-1:0]  RD_H_LD  = PH_W'(RD_HIGH - 1);
    localparam logic [PH_W-1:0]  PH_ONE   = PH_W'(1);
    localparam logic [CNT_W-1:0] PIX_LAST = CNT_W'(FRAME_PIX - 1);

    typedef enum logic [2:0] {
        IDLE,
        WR_L,
        WR_H,
        RD_L,
        RD_H,
        PIX_FETCH,
        PIX_LAT,
        DONE
    } state_t;

    state_t           state;
    logic [PH_W-1:0]  phase;
    logic [CNT_W-1:0] pix_cnt;
    logic             frame_pend;
    logic             gram_phase;   // current frame write is the GRAM command, not a pixel

    // NOTE: every register here is state, so it is assigned only with <= inside this one
    // clocked block; mixing blocking writes in would make results depend on statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            phase         <= '0;
            pix_cnt       <= '0;
            frame_pend    <= 1'b0;
            gram_phase    <= 1'b0;
            frame_busy    <= 1'b0;
            frame_done    <= 1'b0;
            pixel_en      <= 1'b0;
            cmd_ack       <= 1'b0;
            cmd_rdata     <= '0;
            mlcd_cs       <= 1'b1;
            mlcd_wr       <= 1'b1;
            mlcd_rd       <= 1'b1;
            mlcd_rs       <= 1'b1;
            mlcd_data     <= '0;
            mlcd_data_dir <= 1'b1;
        end else begin
            cmd_ack    <= 1'b0;
            frame_done <= 1'b0;
            pixel_en   <= 1'b0;
            if (frame_start) begin
                frame_pend <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (cmd_req) begin
                        mlcd_cs <= 1'b0;
                        mlcd_rs <= cmd_rs;
                        if (cmd_rd) begin
                            mlcd_data_dir <= 1'b0;
                            mlcd_rd       <= 1'b0;
                            phase         <= RD_L_LD;
                            state         <= RD_L;
                        end else begin
                            mlcd_data     <= cmd_wdata;
                            mlcd_data_dir <= 1'b1;
                            mlcd_wr       <= 1'b0;
                            phase         <= WR_L_LD;
                            state         <= WR_L;
                        end
                    end else if (frame_pend) begin
                        // A start arriving on this same edge merges into the accepted frame.
                        frame_pend    <= 1'b0;
                        frame_busy    <= 1'b1;
                        pix_cnt       <= '0;
                        gram_phase    <= 1'b1;
                        mlcd_cs       <= 1'b0;
                        mlcd_rs       <= 1'b0;
                        mlcd_data     <= GRAM_CMD;
                        mlcd_data_dir <= 1'b1;
                        mlcd_wr       <= 1'b0;
                        phase         <= WR_L_LD;
                        state         <= WR_L;
                    end
                end

                WR_L: begin
                    if (phase != '0) begin
                        phase <= phase - PH_ONE;
                    end else begin
                        mlcd_wr <= 1'b1;
                        phase   <= WR_H_LD;
                        state   <= WR_H;
                        if (WR_HIGH == 1) begin
                            cmd_ack <= !frame_busy;
                        end
                    end
                end

                WR_H: begin
                    if (phase != '0) begin
                        phase <= phase - PH_ONE;
                        // cmd_ack is registered, so it is raised one edge ahead of the last cycle.
                        if (phase == PH_ONE) begin
                            cmd_ack <= !frame_busy;
                        end
                    end else if (!frame_busy) begin
                        mlcd_cs <= 1'b1;
                        state   <= IDLE;
                    end else if (gram_phase) begin
                        gram_phase <= 1'b0;
                        pixel_en   <= 1'b1;
                        state      <= PIX_FETCH;
                    end else begin
                        pix_cnt <= pix_cnt + 1'b1;
                        if (pix_cnt == PIX_LAST) begin
                            mlcd_cs    <= 1'b1;
                            frame_busy <= 1'b0;
                            frame_done <= 1'b1;
                            state      <= DONE;
                        end else begin
                            pixel_en <= 1'b1;
                            state    <= PIX_FETCH;
                        end
                    end
                end

                RD_L: begin
                    if (phase != '0) begin
                        phase <= phase - PH_ONE;
                    end else begin
                        cmd_rdata <= mlcd_data_in;
                        mlcd_rd   <= 1'b1;
                        phase     <= RD_H_LD;
                        state     <= RD_H;
                        if (RD_HIGH == 1) begin
                            cmd_ack <= 1'b1;
                        end
                    end
                end

                RD_H: begin
                    if (phase != '0) begin
                        phase <= phase - PH_ONE;
                        if (phase == PH_ONE) begin
                            cmd_ack <= 1'b1;
                        end
                    end else begin
                        mlcd_cs       <= 1'b1;
                        mlcd_data_dir <= 1'b1;
                        state         <= IDLE;
                    end
                end

                PIX_FETCH: begin
                    state <= PIX_LAT;
                end

                PIX_LAT: begin
                    mlcd_data <= pixel_data;
                    mlcd_rs   <= 1'b1;
                    mlcd_wr   <= 1'b0;
                    phase     <= WR_L_LD;
                    state     <= WR_L;
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mlcd_bus_sched.md
Name: mlcd_bus_sched

Overview:
- Sequencer and arbiter for the shared MCU-LCD 8080 bus. It drives the mlcd_* inputs of the LCD signal selector once LCD init is done.
- Serves two requesters: a single-access command port (register write/read from Nios II) and a frame pixel stream (GRAM command followed by FRAME_PIX data writes).
- Generates CS/WR/RD/RS strobes with parameterised timing and drives pixel_en/pixel_data towards the pixel source.

Parameters:
- WR_LOW, 1, clk cycles WR held low per write (≥1)
- WR_HIGH, 1, clk cycles WR held high per write (≥1)
- RD_LOW, 4, clk cycles RD held low per read (≥1)
- RD_HIGH, 4, clk cycles RD held high after read (≥1)
- GRAM_CMD, 16'h2C00, memory-write command issued at frame start (RS=0)
- FRAME_PIX, 384000, pixel writes per frame (480x800)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active low
- frame_start  in  1  pulse: request one frame write
- frame_busy  out  1  high from frame acceptance to frame end
- frame_done  out  1  one-cycle pulse after last pixel
- pixel_en  out  1  one-cycle pixel fetch request
- pixel_data  in  16  pixel, valid the cycle after pixel_en
- cmd_req  in  1  command request level; hold until cmd_ack
- cmd_rd  in  1  1 = read access, 0 = write access
- cmd_rs  in  1  RS level for the access
- cmd_wdata  in  16  write data
- cmd_ack  out  1  one-cycle pulse at access completion
- cmd_rdata  out  16  read data, valid with cmd_ack when cmd_rd=1
- mlcd_cs  out  1  chip select, active low
- mlcd_wr  out  1  write strobe, active low
- mlcd_rd  out  1  read strobe, active low
- mlcd_rs  out  1  0 = command, 1 = data
- mlcd_data  out  16  bus write data
- mlcd_data_dir  out  1  1 = FPGA drives bus
- mlcd_data_in  in  16  bus read data

Behaviour:
- Reset values (async): cs=1, wr=1, rd=1, rs=1, data=0, dir=1, pixel_en=0, cmd_ack=0, cmd_rdata=0, frame_busy=0, frame_done=0, pix counter=0, frame_pend=0. A reset mid-access forces the bus idle immediately; there is no completion pulse.
- frame_start is latched into frame_pend in any state, including busy. A second start while one is pending or active merges with it, so at most one frame is queued.
- States: IDLE, WR_L, WR_H, RD_L, RD_H, PIX_FETCH, PIX_LAT, DONE. A single phase counter is loaded with (param−1) on entry to each timed state.
- Arbitration in IDLE:
  - cmd_req has priority over frame_pend.
  - A frame is never interrupted. cmd_req is only evaluated in IDLE.
- Command write:
  - IDLE→WR_L: cs=0, rs=cmd_rs, data=cmd_wdata, dir=1, wr=0 for WR_LOW cycles.
  - WR_H: wr=1 for WR_HIGH cycles.
  - Last WR_H cycle: cmd_ack=1, then IDLE with cs=1.
- Command read:
  - IDLE→RD_L: cs=0, rs=cmd_rs, dir=0, rd=0 for RD_LOW cycles. mlcd_data_in is sampled into cmd_rdata on the last RD_L cycle.
  - RD_H: rd=1 for RD_HIGH cycles. Last cycle: cmd_ack=1, then dir=1, IDLE.
- Frame sequence:
  - IDLE with frame_pend and no cmd_req: clear frame_pend, set frame_busy=1, pix counter=0.
  - Write GRAM_CMD with rs=0 (WR_L/WR_H). cs stays 0 for the whole frame.
  - Then per pixel:
    - PIX_FETCH: pixel_en=1 for 1 cycle.
    - PIX_LAT: latch pixel_data into data, rs=1.
    - WR_L/WR_H: write strobe. On the last WR_H cycle, increment the counter.
    - If counter==FRAME_PIX−1, go to DONE, else PIX_FETCH.
  - DONE: cs=1, frame_busy=0, frame_done=1 for 1 cycle, then IDLE.
- Per-pixel period = 2+WR_LOW+WR_HIGH cycles. Defaults give 4 clk/pixel.
- cmd_ack is never asserted during a frame. cmd_req raised mid-frame is served in the first IDLE after DONE, ahead of any pending frame.
- Pixel counter width is clog2(FRAME_PIX). No wrap occurs because the counter is cleared at frame start.
- Only one of wr/rd is ever low. Both are 1 whenever cs=1.

Test Plan:
- Reset, then a command write with cmd_rs=0, cmd_wdata=16'h1100 → cs=0, rs=0, data=1100 and wr low for 1 cycle then high for 1 cycle. cmd_ack pulses on cycle 2, and cs=1 afterwards.
- Command read with cmd_rs=1 and mlcd_data_in=16'h5510 → dir=0 and rd low for 4 cycles. cmd_rdata=5510 with cmd_ack 8 cycles after the start, then dir=1.
- FRAME_PIX=4, frame_start, source returns 16'hF800+n:
  - First write is 2C00 with rs=0.
  - Then 4 writes F800..F803 with rs=1, 4 pixel_en pulses and 4 clk/pixel.
  - frame_done pulses once, and cs stays low throughout.
- cmd_req and frame_start asserted in the same cycle → the command completes first, then the frame begins. frame_busy=0 until cmd_ack.
- cmd_req raised at pixel 2 of 4 → no bus change, and cmd_ack is delayed until after frame_done. frame_start during the frame → exactly one further frame runs.
- rst_n pulsed low in the middle of a WR_L → all bus outputs return to reset values asynchronously. After release the next frame_start restarts with GRAM_CMD and the counter at 0.
